// File: rtl/crc_pkg.sv
// Shared types, constants and the bit-serial CRC update used by the streaming
// CRC generator and by anything that needs a reference model of it.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_APPEND
  } crc_state_e;

  localparam int CRC_MAX    = 64;
  localparam int DATA_MAX   = 64;
  localparam int CRC_IDX_W  = $clog2(CRC_MAX);
  localparam int DATA_IDX_W = $clog2(DATA_MAX);

  localparam logic [15:0] CRC16_CCITT      = 16'h1021;
  localparam logic [15:0] CRC16_INIT_ZERO  = 16'h0000;
  localparam logic [15:0] CRC16_INIT_ONES  = 16'hFFFF;
  localparam logic [31:0] CRC32_ETH        = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT_ONES  = 32'hFFFFFFFF;

  // Folds the low data_w bits of data, MSB first, into the low crc_w bits of crc.
  // Bits above crc_w in the result are don't-care; callers truncate.
  function automatic logic [CRC_MAX-1:0] crc_fold(
    input logic [CRC_MAX-1:0]  crc,
    input logic [DATA_MAX-1:0] data,
    input logic [CRC_MAX-1:0]  poly,
    input int                  crc_w,
    input int                  data_w
  );
    logic [CRC_MAX-1:0] c;
    logic               fb;
    c = crc;
    for (int i = DATA_MAX - 1; i >= 0; i--) begin
      if (i < data_w) begin
        fb = c[CRC_IDX_W'(crc_w - 1)] ^ data[DATA_IDX_W'(i)];
        c  = {c[CRC_MAX-2:0], 1'b0} ^ (fb ? poly : '0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_stream_gen_if.sv
// Stream-in / stream-out bundle of the CRC generator, plus its result outputs.
interface crc_stream_gen_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_done;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, crc_out, crc_done
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, crc_out, crc_done
  );
endinterface

// File: rtl/crc_beat_fold.sv
// Combinational update of a CRC register by one full DATA_W-bit beat.
module crc_beat_fold
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 16,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = 16'h1021
) (
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [CRC_W-1:0]  crc_out
);

  assign crc_out = CRC_W'(crc_fold(CRC_MAX'(crc_in), DATA_MAX'(data_in),
                                   CRC_MAX'(POLY), CRC_W, DATA_W));

endmodule

// File: rtl/crc_stream_gen.sv
// Streaming CRC generator: forwards each input beat through one output register,
// then appends (crc ^ XOR_OUT) as CRC_W/DATA_W beats, most-significant slice first.
module crc_stream_gen
  import crc_pkg::*;
#(
  parameter int               CRC_W   = 16,
  parameter int               DATA_W  = 8,
  parameter logic [CRC_W-1:0] POLY    = 16'h1021,
  parameter logic [CRC_W-1:0] INIT    = 16'h0000,
  parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  crc_stream_gen_if.slave bus
);

  localparam int N     = CRC_W / DATA_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  crc_state_e        state_q, state_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CRC_W-1:0]  crc_out_q, crc_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              crc_done_q, crc_done_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;

  logic [CRC_W-1:0]  crc_next;
  logic [CRC_W-1:0]  crc_fin;
  logic              s_ready;
  logic              s_accept;
  logic              m_fire;

  crc_beat_fold #(
    .CRC_W (CRC_W),
    .DATA_W(DATA_W),
    .POLY  (POLY)
  ) u_fold (
    .crc_in (crc_q),
    .data_in(bus.s_data),
    .crc_out(crc_next)
  );

  assign crc_fin  = crc_q ^ XOR_OUT;
  assign s_ready  = !rst && (state_q != ST_APPEND) && (!m_valid_q || bus.m_ready);
  assign s_accept = bus.s_valid && s_ready;
  assign m_fire   = m_valid_q && bus.m_ready;

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches);
    // blocking assignments are correct here because this block is purely combinational.
    state_d    = state_q;
    crc_d      = crc_q;
    crc_out_d  = crc_out_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_fire ? 1'b0 : m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    crc_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DATA: begin
        if (s_accept) begin
          crc_d     = crc_next;
          m_valid_d = 1'b1;
          m_data_d  = bus.s_data;
          m_last_d  = 1'b0;
          state_d   = bus.s_last ? ST_APPEND : ST_DATA;
        end
      end
      ST_APPEND: begin
        if (m_fire && m_last_q) begin
          crc_out_d  = crc_fin;
          crc_done_d = 1'b1;
          crc_d      = INIT;
          cnt_d      = '0;
          m_last_d   = 1'b0;
          state_d    = ST_IDLE;
        end else if (!m_valid_q || m_fire) begin
          // Output register is free: present the next CRC slice.
          m_valid_d = 1'b1;
          m_data_d  = DATA_W'(crc_fin >> (DATA_W * (N - 1 - int'(cnt_q))));
          m_last_d  = (cnt_q == CNT_W'(N - 1));
          if (cnt_q != CNT_W'(N - 1)) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= INIT;
      crc_out_q  <= '0;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      crc_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      crc_out_q  <= crc_out_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      crc_done_q <= crc_done_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_last   = m_last_q;
  assign bus.crc_out  = crc_out_q;
  assign bus.crc_done = crc_done_q;

endmodule
